mem_line_responder: RTL and testbench

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_responder.sv | 129 ++++++++++++
 tb/tb_mem_line_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Line-granular memory responder: one outstanding line fill or writeback,
// answered a fixed number of cycles after acceptance with a ready/valid response.
module mem_line_responder #(
  parameter int WORD_SIZE   = 32,
  parameter int LINE_SIZE   = WORD_SIZE * 4,
  parameter int MEMORY_SIZE = 65536,
  parameter int ADDR_LENGTH = $clog2(MEMORY_SIZE),
  parameter int MEM_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [LINE_SIZE-1:0]   req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LINE_SIZE-1:0]   resp_rdata
);

  localparam int OFFSET_BITS = $clog2(LINE_SIZE / 8);
  localparam int NUM_LINES   = MEMORY_SIZE * 8 / LINE_SIZE;
  localparam int IDX_W       = ADDR_LENGTH - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 write_q, write_d;
  logic [LINE_SIZE-1:0] wdata_q, wdata_d;
  logic [LINE_SIZE-1:0] rdata_q, rdata_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;

  logic [LINE_SIZE-1:0] line_mem [NUM_LINES];
  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [LINE_SIZE-1:0] rd_line;
  logic                 accept;
  logic                 mem_we;
  logic                 unused_offset;

  assign req_idx       = req_addr[ADDR_LENGTH-1:OFFSET_BITS];
  assign unused_offset = &{1'b0, req_addr[OFFSET_BITS-1:0]};
  assign accept        = (state_q == IDLE) && req_valid;
  assign mem_we        = accept && req_write;
  // Single-cycle latency reads the incoming index; otherwise the latched one.
  assign rd_idx        = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_line       = line_mem[rd_idx];

  // Storage has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_mem[req_idx] <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_idx;
          write_d = req_write;
          wdata_d = req_wdata;
          if (MEM_LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            rdata_d = req_write ? req_wdata : rd_line;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(MEM_LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // Leaving on the edge that brings the count to zero puts the first
        // response cycle exactly MEM_LATENCY cycles after acceptance.
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = write_q ? wdata_q : rd_line;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: default build plus a MEM_LATENCY=1 build.
module tb_mem_line_responder;

  localparam int MEM_LATENCY = 4;
  localparam logic [127:0] D0 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] D3 = 128'h00000003_00000002_00000001_00000000;
  localparam logic [127:0] D4 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid, resp_ready;
  logic [127:0] resp_rdata;

  logic         req_valid_l1, req_ready_l1, req_write_l1;
  logic [15:0]  req_addr_l1;
  logic [127:0] req_wdata_l1;
  logic         resp_valid_l1, resp_ready_l1;
  logic [127:0] resp_rdata_l1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_line_responder #(.MEM_LATENCY(MEM_LATENCY)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
  );

  mem_line_responder #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_write(req_write_l1),
    .req_addr(req_addr_l1), .req_wdata(req_wdata_l1),
    .resp_valid(resp_valid_l1), .resp_ready(resp_ready_l1), .resp_rdata(resp_rdata_l1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input logic [127:0] exp,
                        input int hold, input bit junk);
    int lat;
    check({tag, " req_ready"}, 128'(req_ready), 128'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(MEM_LATENCY));
    check({tag, " rdata"}, resp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      req_valid = junk; req_write = 1'b1; req_wdata = ~exp;
      @(negedge clk);
      check({tag, " hold resp_valid"}, 128'(resp_valid), 128'd1);
      check({tag, " hold rdata"}, resp_rdata, exp);
      check({tag, " hold req_ready"}, 128'(req_ready), 128'd0);
    end
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " req_ready after"}, 128'(req_ready), 128'd1);
    check({tag, " resp_valid after"}, 128'(resp_valid), 128'd0);
    $display("txn %s: wr=%0b addr=%h latency=%0d rdata=%h", tag, wr, addr, lat, exp);
  endtask

  initial begin
    int acc_cnt, resp_cnt, last_acc;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid_l1 = 1'b0; req_write_l1 = 1'b0; req_addr_l1 = '0; req_wdata_l1 = '0;
    resp_ready_l1 = 1'b0;
    #23;
    check("reset req_ready", 128'(req_ready), 128'd1);
    check("reset resp_valid", 128'(resp_valid), 128'd0);
    check("reset resp_rdata", resp_rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release accepts (latency check would fail otherwise).
    do_req("wr line0", 1'b1, 16'h0000, D0, D0, 0, 1'b0);
    do_req("wr 0x0010", 1'b1, 16'h0010, D1, D1, 0, 1'b0);
    do_req("rd 0x001C", 1'b0, 16'h001C, '0, D1, 0, 1'b0);

    // Back-pressure with a write attempt to the same line that must be ignored.
    do_req("wr 0x0020", 1'b1, 16'h0020, D3, D3, 0, 1'b0);
    do_req("rd 0x0020 bp", 1'b0, 16'h0020, '0, D3, 10, 1'b1);
    do_req("rd 0x0020 again", 1'b0, 16'h0028, '0, D3, 0, 1'b0);

    do_req("wr top", 1'b1, 16'hFFF0, D2, D2, 0, 1'b0);
    do_req("rd top", 1'b0, 16'hFFFF, '0, D2, 0, 1'b0);
    do_req("rd line0", 1'b0, 16'h0004, '0, D0, 0, 1'b0);

    // Reset two cycles into a read.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(posedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst resp_valid", 128'(resp_valid), 128'd0);
    check("midrst req_ready", 128'(req_ready), 128'd1);
    check("midrst resp_rdata", resp_rdata, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst no resp", 128'(resp_valid), 128'd0);
    end
    $display("txn reset mid-read: aborted");
    do_req("rd after rst", 1'b0, 16'h0010, '0, D1, 0, 1'b0);

    // Continuous requests: acceptances every MEM_LATENCY+1 cycles.
    acc_cnt = 0; resp_cnt = 0; last_acc = -1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; resp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) begin
        if (last_acc >= 0)
          check("stream spacing", 128'(i - last_acc), 128'(MEM_LATENCY + 1));
        last_acc = i;
        acc_cnt++;
      end
      if (resp_valid) begin
        resp_cnt++;
        check("stream rdata", resp_rdata, D1);
      end
      check("stream overlap", 128'(req_ready & resp_valid), 128'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    check("stream accepts", 128'(acc_cnt), 128'd6);
    check("stream responses", 128'(resp_cnt), 128'd6);
    $display("txn stream: %0d accepts %0d responses", acc_cnt, resp_cnt);
    repeat (6) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // MEM_LATENCY=1 build: response on the cycle after acceptance.
    req_valid_l1 = 1'b1; req_write_l1 = 1'b1; req_addr_l1 = 16'h0040; req_wdata_l1 = D4;
    @(negedge clk);
    req_valid_l1 = 1'b0; req_write_l1 = 1'b0; req_wdata_l1 = '0;
    check("l1 wr resp_valid", 128'(resp_valid_l1), 128'd1);
    check("l1 wr rdata", resp_rdata_l1, D4);
    resp_ready_l1 = 1'b1;
    @(negedge clk);
    resp_ready_l1 = 1'b0;
    check("l1 wr req_ready", 128'(req_ready_l1), 128'd1);
    $display("txn l1 write 0x0040: rdata=%h", resp_rdata_l1);
    req_valid_l1 = 1'b1; req_addr_l1 = 16'h004C;
    @(negedge clk);
    req_valid_l1 = 1'b0;
    check("l1 rd resp_valid", 128'(resp_valid_l1), 128'd1);
    check("l1 rd rdata", resp_rdata_l1, D4);
    resp_ready_l1 = 1'b1;
    @(negedge clk);
    resp_ready_l1 = 1'b0;
    check("l1 rd resp_valid after", 128'(resp_valid_l1), 128'd0);
    $display("txn l1 read 0x004C: rdata=%h", D4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
